// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   - state_t    : frame sequencer state encoding (also exported for debug)
//   - LINE_IDLE  : level of an idle line and of stop bits
//   - START_BIT  : level of the start bit
//   - EVEN / ODD : parity type encoding forwarded to the parity calculator
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Prescale counter that divides clk down to the line bit rate.
// The count runs 0..CLKS_PER_BIT-1 while enabled; o_bit_tick marks the last
// clock of each line bit (count == CLKS_PER_BIT-1).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_en        : advance the count this cycle
//   i_clr       : force the count to zero (has priority over i_en)
//   o_count     : current prescale count
//   o_bit_tick  : bit boundary strobe
// ---------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_bit_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_count    = r_count;
  assign o_bit_tick = i_en && !i_clr && w_last;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_ctrl
// Transmit frame sequencer: latches one word per frame, strobes the external
// parity calculator, and serializes start, data (LSB first), optional parity
// and stop bits at CLKS_PER_BIT clocks per line bit. All outputs registered.
//
// Request handshake: data_valid is a valid-only request with no ready. It is
// taken on a rising edge where the block is in IDLE (busy=0); a request seen
// in any other state, including the done cycle, is dropped, not queued.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   data_valid      : send request (honoured only in IDLE)
//   data_in         : word to transmit
//   parity_enable   : sampled at acceptance; 1 = insert parity bit
//   parity_type     : sampled at acceptance; 0 = even, 1 = odd
//   parity_bit      : parity result from the external calculator
//   par_load        : one-cycle load strobe to the parity calculator
//   par_type        : latched parity type for the parity calculator
//   par_data        : latched word for the parity calculator
//   tx_out          : serial line, idle high
//   busy            : frame in progress
//   done            : one-cycle pulse in the final cycle of the frame
//   dbg_state       : current sequencer state (uart_pkg::state_t encoding)
// ---------------------------------------------------------------------------
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_valid,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic                 parity_enable,
  input  logic                 parity_type,
  input  logic                 parity_bit,
  output logic                 par_load,
  output logic                 par_type,
  output logic [DATAWIDTH-1:0] par_data,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATAWIDTH);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATAWIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  // done is registered, so it is set one count before the final stop tick
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);

  // Registered state
  state_t               r_state;
  logic [DATAWIDTH-1:0] r_shift;
  logic [DATAWIDTH-1:0] r_par_data;
  logic                 r_par_type;
  logic                 r_par_en;
  logic                 r_par_load;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_cnt;

  // Next-state values
  state_t               w_nxt_state;
  logic [DATAWIDTH-1:0] w_nxt_shift;
  logic [DATAWIDTH-1:0] w_nxt_par_data;
  logic                 w_nxt_par_type;
  logic                 w_nxt_par_en;
  logic                 w_nxt_par_load;
  logic                 w_nxt_tx;
  logic                 w_nxt_busy;
  logic                 w_nxt_done;
  logic [IDX_W-1:0]     w_nxt_bit_idx;
  logic                 w_nxt_stop_cnt;

  // Bit timer
  logic [CNT_W-1:0]     w_count;
  logic                 w_bit_tick;
  logic                 w_timer_en;
  logic                 w_timer_clr;

  // Held at zero in IDLE so the START bit always gets a full period.
  assign w_timer_en  = (r_state != ST_IDLE);
  assign w_timer_clr = (r_state == ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_timer_en),
    .i_clr      (w_timer_clr),
    .o_count    (w_count),
    .o_bit_tick (w_bit_tick)
  );

  // Next-state and output logic
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_shift    = r_shift;
    w_nxt_par_data = r_par_data;
    w_nxt_par_type = r_par_type;
    w_nxt_par_en   = r_par_en;
    w_nxt_par_load = 1'b0;
    w_nxt_tx       = r_tx;
    w_nxt_busy     = r_busy;
    w_nxt_done     = 1'b0;
    w_nxt_bit_idx  = r_bit_idx;
    w_nxt_stop_cnt = r_stop_cnt;

    case (r_state)
      ST_IDLE: begin
        w_nxt_tx   = LINE_IDLE;
        w_nxt_busy = 1'b0;
        if (data_valid) begin
          w_nxt_state    = ST_START;
          w_nxt_shift    = data_in;
          w_nxt_par_data = data_in;
          w_nxt_par_type = parity_type;
          w_nxt_par_en   = parity_enable;
          w_nxt_par_load = 1'b1;
          w_nxt_tx       = START_BIT;
          w_nxt_busy     = 1'b1;
        end
      end

      ST_START: begin
        if (w_bit_tick) begin
          w_nxt_state   = ST_DATA;
          w_nxt_tx      = r_shift[0];
          w_nxt_shift   = r_shift >> 1;
          w_nxt_bit_idx = '0;
        end
      end

      ST_DATA: begin
        if (w_bit_tick) begin
          if (r_bit_idx == LAST_IDX) begin
            w_nxt_stop_cnt = 1'b0;
            if (r_par_en) begin
              w_nxt_state = ST_PARITY;
              // Calculator was loaded long ago, so parity_bit is settled here.
              w_nxt_tx    = parity_bit;
            end else begin
              w_nxt_state = ST_STOP;
              w_nxt_tx    = LINE_IDLE;
            end
          end else begin
            w_nxt_tx      = r_shift[0];
            w_nxt_shift   = r_shift >> 1;
            w_nxt_bit_idx = r_bit_idx + IDX_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (w_bit_tick) begin
          w_nxt_state    = ST_STOP;
          w_nxt_tx       = LINE_IDLE;
          w_nxt_stop_cnt = 1'b0;
        end
      end

      ST_STOP: begin
        w_nxt_done = (r_stop_cnt == LAST_STOP) && (w_count == PRE_LAST);
        if (w_bit_tick) begin
          if (r_stop_cnt == LAST_STOP) begin
            w_nxt_state = ST_IDLE;
            w_nxt_busy  = 1'b0;
          end else begin
            w_nxt_stop_cnt = r_stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_tx    = LINE_IDLE;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_par_data <= '0;
      r_par_type <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_load <= 1'b0;
      r_tx       <= LINE_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_shift    <= w_nxt_shift;
      r_par_data <= w_nxt_par_data;
      r_par_type <= w_nxt_par_type;
      r_par_en   <= w_nxt_par_en;
      r_par_load <= w_nxt_par_load;
      r_tx       <= w_nxt_tx;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_bit_idx  <= w_nxt_bit_idx;
      r_stop_cnt <= w_nxt_stop_cnt;
    end
  end

  assign par_load  = r_par_load;
  assign par_type  = r_par_type;
  assign par_data  = r_par_data;
  assign tx_out    = r_tx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
// Two instances share one stimulus stream: g_inst[0] with one stop bit and
// g_inst[1] with two. Each has a frame-level reference model that expands
// an accepted request into the list of per-cycle output words; one compare
// process checks every cycle and also records mid-bit line samples so a few
// hand-written frames pin the model against literal bit patterns.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_frame_ctrl;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int W   = 16;   // {state[2:0], par_data[7:0], par_type, par_load, done, busy, tx}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          parity_enable = 1'b0;
  logic          parity_type = 1'b0;

  always #5 clk = ~clk;

  logic [W-1:0] act_w [2];
  logic [W-1:0] exp_w [2];

  int   n_chk = 0;
  int   n_err = 0;
  int   pin_id = 0;
  logic fin_req = 1'b0;

  // ---------------- DUTs and reference models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int SB = g + 1;

    logic          tx, bsy, dn, pl, pt_o, pb;
    logic [DW-1:0] pd;
    logic [2:0]    st;

    // External parity calculator: even -> XOR of data, odd -> its inverse.
    assign pb = (^pd) ^ pt_o;

    uart_tx_frame_ctrl #(
      .DATAWIDTH    (DW),
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (SB)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .data_valid    (data_valid),
      .data_in       (data_in),
      .parity_enable (parity_enable),
      .parity_type   (parity_type),
      .parity_bit    (pb),
      .par_load      (pl),
      .par_type      (pt_o),
      .par_data      (pd),
      .tx_out        (tx),
      .busy          (bsy),
      .done          (dn),
      .dbg_state     (st)
    );

    // Scoreboard: exp_q holds the expected output word for each coming cycle
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_now = W'(1);
    logic [DW-1:0] hold_pd = '0;
    logic          hold_pt = 1'b0;
    logic [15:0]   lb;
    int            nb;
    int            pe_i;
    int            b;
    logic [2:0]    es;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        exp_q.delete();
        hold_pd = '0;
        hold_pt = 1'b0;
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (data_valid) begin
        hold_pd = data_in;
        hold_pt = parity_type;
        pe_i    = parity_enable ? 1 : 0;
        nb      = 1 + DW + pe_i + SB;
        lb      = '0;
        lb[0]   = START_BIT;
        for (int i = 0; i < DW; i++) lb[1 + i] = data_in[i];
        if (parity_enable) lb[1 + DW] = (^data_in) ^ (parity_type == ODD);
        for (int s = 0; s < SB; s++) lb[1 + DW + pe_i + s] = LINE_IDLE;
        for (int k = 0; k < nb * CPB; k++) begin
          b = k / CPB;
          if (b == 0)                            es = 3'd1;
          else if (b <= DW)                      es = 3'd2;
          else if (parity_enable && b == DW + 1) es = 3'd3;
          else                                   es = 3'd4;
          exp_q.push_back({es, data_in, parity_type, (k == 0),
                           (k == nb * CPB - 1), 1'b1, lb[b]});
        end
      end
      exp_now = (exp_q.size() != 0) ? exp_q[0] : {3'd0, hold_pd, hold_pt, 4'b0001};
    end

    assign exp_w[g] = exp_now;
    assign act_w[g] = {st, pd, pt_o, pl, dn, bsy, tx};
  end

  // ---------------- literal frames ----------------
  function automatic int pin_inst(input int id);
    return (id == 5) ? 1 : 0;
  endfunction

  function automatic int pin_len(input int id);
    case (id)
      4:       return 40;
      5:       return 48;
      default: return 44;
    endcase
  endfunction

  // bit i = i-th line bit (start is bit 0)
  function automatic logic [15:0] pin_bits(input int id);
    case (id)
      1:       return 16'b1_0_10100101_0;   // 0xA5 even
      2:       return 16'b1_1_10100101_0;   // 0xA5 odd
      3:       return 16'b1_0_00000111_0;   // 0x07 odd
      4:       return 16'b1_00111100_0;     // 0x3C no parity
      5:       return 16'b11_0_00000000_0;  // 0x00 even, two stops
      default: return 16'h0;
    endcase
  endfunction

  // ---------------- compare process ----------------
  logic        rec_on [2];
  int          rec_k [2];
  logic [15:0] rec_bits [2];
  int          pins_seen = 0;
  int          n_prt = 0;
  logic        fin_done = 1'b0;

  initial begin
    for (int g = 0; g < 2; g++) begin
      rec_on[g]   = 1'b0;
      rec_k[g]    = 0;
      rec_bits[g] = '0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      n_chk++;
      if (act_w[g] !== exp_w[g]) begin
        n_err++;
        if (n_prt < 20)
          $display("FAIL cycle inst%0d t=%0t got=%h exp=%h", g, $time, act_w[g], exp_w[g]);
        n_prt++;
      end
      if (rst) begin
        rec_on[g] = 1'b0;
      end else begin
        if (act_w[g][3] === 1'b1) begin
          rec_on[g]   = 1'b1;
          rec_k[g]    = 0;
          rec_bits[g] = '0;
        end
        if (rec_on[g]) begin
          rec_k[g]++;
          if (((rec_k[g] - 1) % CPB) == CPB / 2 && ((rec_k[g] - 1) / CPB) < 16)
            rec_bits[g][(rec_k[g] - 1) / CPB] = act_w[g][0];
          if (act_w[g][2] === 1'b1) begin
            rec_on[g] = 1'b0;
            if (pin_id != 0 && pin_inst(pin_id) == g) begin
              pins_seen++;
              n_chk++;
              if (rec_k[g] != pin_len(pin_id)) begin
                n_err++;
                $display("FAIL frame_len pin%0d got=%0d exp=%0d", pin_id, rec_k[g], pin_len(pin_id));
              end
              n_chk++;
              if (rec_bits[g] !== pin_bits(pin_id)) begin
                n_err++;
                $display("FAIL frame_bits pin%0d got=%b exp=%b", pin_id, rec_bits[g], pin_bits(pin_id));
              end
            end
          end
        end
      end
    end
    if (fin_req && !fin_done) begin
      fin_done = 1'b1;
      n_chk++;
      if (pins_seen != 5) begin
        n_err++;
        $display("FAIL pinned_frames got=%0d exp=5", pins_seen);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  // Present a request for one cycle, then scramble the config inputs so a
  // frame that still looked at them would show up on the line.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    data_valid    = 1'b1;
    data_in       = d;
    parity_enable = pe;
    parity_type   = pt;
    tick();
    data_valid    = 1'b0;
    data_in       = DW'($urandom);
    parity_enable = 1'($urandom);
    parity_type   = 1'($urandom);
  endtask

  task automatic pinned(input int id, input logic [DW-1:0] d, input logic pe, input logic pt);
    pin_id = id;
    send(d, pe, pt);
    cycles(60);
    pin_id = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(3);

    pinned(1, 8'hA5, 1'b1, EVEN);
    pinned(2, 8'hA5, 1'b1, ODD);
    pinned(3, 8'h07, 1'b1, ODD);
    pinned(4, 8'h3C, 1'b0, EVEN);
    pinned(5, 8'h00, 1'b1, EVEN);

    // Request mid-frame is dropped; the line carries only 0x12.
    send(8'h12, 1'b1, EVEN);
    cycles(10);
    data_valid = 1'b1;
    data_in    = 8'hFF;
    cycles(5);
    data_valid = 1'b0;
    cycles(55);

    // Reset during data bit 3, then a clean 0x55 frame.
    send(8'h96, 1'b1, EVEN);
    cycles(17);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    send(8'h55, 1'b1, ODD);
    cycles(60);

    // Request held high across frame ends: next accept is the first idle cycle.
    data_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      data_in       = DW'($urandom);
      parity_enable = 1'($urandom);
      parity_type   = 1'($urandom);
      tick();
    end
    data_valid = 1'b0;
    cycles(60);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      data_valid    = ($urandom_range(0, 7) == 0);
      data_in       = DW'($urandom);
      parity_enable = 1'($urandom);
      parity_type   = 1'($urandom);
      rst           = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst        = 1'b0;
    data_valid = 1'b0;
    cycles(60);

    fin_req = 1'b1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Transmit-side frame sequencer for the UART V3 path.
- Accepts one data word per frame and latches it.
- Strobes the parity calculator (load strobe plus parity type) and serializes start, data LSB-first, optional parity, and stop bits onto the line at CLKS_PER_BIT clocks per bit.
- Owns the frame state machine and bit timing; parity value is produced externally and consumed here.

Parameters:
DATAWIDTH, 8, data bits per frame (legal 5..9)
CLKS_PER_BIT, 16, clk cycles per line bit (>=2)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
data_valid  input  1  request to send data_in; honoured only in IDLE
data_in  input  DATAWIDTH  word to transmit
parity_enable  input  1  sampled at acceptance; 1 = insert parity bit
parity_type  input  1  sampled at acceptance; 0 = even, 1 = odd
parity_bit  input  1  parity result from the external parity calculator
par_load  output  1  one-cycle strobe to the parity calculator's data-valid input
par_type  output  1  latched parity_type, forwarded to the parity calculator
par_data  output  DATAWIDTH  latched word, forwarded to the parity calculator data input
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, any state, including mid-frame):
  - state=IDLE, tx_out=1, busy=0, done=0, par_load=0, par_type=0, par_data=0.
  - Bit counter and prescale counter cleared.
  - Partial frame is abandoned. After release the line stays high until the next accept.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Accept: in IDLE with data_valid=1 at edge T0:
  - latch data_in into the shift register and par_data;
  - latch parity_enable and parity_type, driving par_type;
  - par_load=1 for exactly the cycle after T0.
  - From T0+1: state=START, tx_out=0, busy=1.
- data_valid is ignored while busy=1. No queuing and no error flag.
- Each state's line bit lasts CLKS_PER_BIT cycles.
  - Prescale counter runs 0..CLKS_PER_BIT-1; a bit boundary occurs when the count reaches CLKS_PER_BIT-1.
- START -> DATA at bit boundary.
- DATA:
  - tx_out = shift register LSB; shift right at each bit boundary.
  - Bit index counts 0..DATAWIDTH-1.
  - After bit DATAWIDTH-1: go to PARITY if parity enabled, else STOP.
- PARITY:
  - tx_out = parity_bit, registered on entry and held for the bit.
  - The parity input is stable because the parity calculator was loaded at T0+1, well before this point.
  - -> STOP at bit boundary.
- STOP:
  - tx_out=1 for STOP_BITS bit periods.
  - done=1 in the final clk cycle of the last stop bit.
  - Next cycle: state=IDLE, busy=0, done=0.
- Frame length = (1 + DATAWIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = parity_enable. Counted from T0+1 through the done cycle inclusive.
- Back-to-back: a data_valid asserted during the done cycle is ignored. The earliest accept is the first IDLE cycle, giving a minimum of 1 idle-high cycle between frames.
- Config inputs changing mid-frame have no effect on the current frame.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - line constants LINE_IDLE=1, START_BIT=0;
  - parity type constants EVEN=0, ODD=1.
- One natural sub-module, uart_bit_timer: prescale counter with enable/clear inputs and a bit_tick output.
- The FSM, shift register and bit/stop counters stay in this block.
- The parity calculator is instantiated alongside, at the UART TX top level, not inside this block.

Test Plan:
- Even parity: DATAWIDTH=8, CLKS_PER_BIT=4, data_in=0xA5, parity_enable=1, parity_type=0.
  - par_load pulses at T0+1; tx_out bits = 0,1,0,1,0,0,1,0,1,0(par),1.
  - 44 cycles total; done at cycle 44; busy low at cycle 45.
- Odd parity: 0xA5 with parity_type=1 -> parity bit 1, else as above.
  - 0x07 with odd parity -> parity bit 0.
- Parity disabled: 0x3C, parity_enable=0 -> 10 bits (0,0,0,1,1,1,1,0,0,1), 40 cycles; no PARITY state entered.
- Ignored request: assert data_valid with 0xFF mid-frame of 0x12 -> line shows only 0x12; next frame starts only on a fresh request in IDLE.
- Reset mid-frame: assert rst in DATA bit 3 -> tx_out=1, busy=0, par_load=0 the same cycle.
  - After release, a 0x55 frame transmits cleanly.
- Two stop bits: STOP_BITS=2, 0x00, even parity -> stop high for 8 cycles; total 48 cycles; done single-cycle.
